mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 2: maximum accepted-but-unanswered memory requests; power of two, >= 1.
REQ-002 Parameter N_REQ, fixed at 2: requester 0 is instruction fetch, requester 1 is load/store.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m_req[N_REQ]  decoupled#(mreq) sink  per-requester request (a, we, d, be) with valid/ready.
REQ-006 m_resp[N_REQ]  decoupled#(mtrans) source  per-requester response data with valid/ready.
REQ-007 mem_req  decoupled#(mreq) source  shared downstream memory request.
REQ-008 mem_resp  decoupled#(mtrans) sink  shared downstream response; memory returns responses strictly in request order.

Function
REQ-009 Request path SHALL be zero-latency: mem_req.data and mem_req.valid driven combinationally from the granted requester; m_req[g].ready = mem_req.ready AND grant-eligible; m_req[other].ready = 0.
REQ-010 Arbitration SHALL be round-robin: rr_ptr names the preferred requester; if both valid, rr_ptr wins; if one valid, it wins.
REQ-011 On each accepted request (mem_req.valid AND mem_req.ready), rr_ptr SHALL become the non-granted requester's index.
REQ-012 Lock: when mem_req.valid AND NOT mem_req.ready, the grant SHALL stay on the same requester next cycle regardless of other valids (no switching mid-handshake); lock clears on acceptance.
REQ-013 A tag FIFO of depth OUTSTANDING SHALL record the requester index of every accepted request, pushed at acceptance.
REQ-014 FIFO full SHALL force mem_req.valid = 0 and all m_req ready = 0; a same-cycle pop does NOT enable a push (no full-bypass).
REQ-015 Response routing: when FIFO non-empty, m_resp[head].valid = mem_resp.valid, m_resp[head].data = mem_resp.data, mem_resp.ready = m_resp[head].ready; other m_resp valid = 0.
REQ-016 FIFO SHALL pop on mem_resp.valid AND mem_resp.ready; push and pop in the same cycle (not full) leave occupancy unchanged.
REQ-017 FIFO empty SHALL force mem_resp.ready = 0 and all m_resp valid = 0; a stray mem_resp.valid is held off, never delivered.
REQ-018 FIFO pointers SHALL be log2(OUTSTANDING) bits wrapping modulo OUTSTANDING; count SHALL be log2(OUTSTANDING)+1 bits.
REQ-019 Acceptance of a new request and delivery of an older response in the same cycle SHALL both complete.

Reset
REQ-020 On rst: FIFO empty (count 0, pointers 0), rr_ptr = 0, lock cleared; mem_req.valid, all m_req ready, all m_resp valid, mem_resp.ready = 0 during and the cycle after reset deasserts only as the REQ-009..017 equations give.
REQ-021 Reset mid-transaction SHALL discard all outstanding tags; the memory side is reset by the same rst.

Structure
REQ-022 N_REQ, requester index constants (REQ_IF = 0, REQ_LS = 1) and the requester-id typedef SHALL live in the shared types package next to mreq/mtrans.
REQ-023 The tag FIFO SHALL be a separate sub-module, tag_fifo (parameters DEPTH, WIDTH), reusable elsewhere.

Verification
REQ-024 Both valid from reset, mem_req.ready = 1, responses immediate: grants alternate 0,1,0,1; each response returns to the issuing requester.
REQ-025 Requester 1 valid, mem_req.ready = 0 for 3 cycles, requester 0 raises valid in cycle 2: grant stays on 1 until accepted, then 0 granted next.
REQ-026 OUTSTANDING = 2, responses withheld: two requests accepted, third blocked (ready = 0) until one response pops; then accepted one cycle later.
REQ-027 Requester 0 issues A, requester 1 issues B, in-order responses 0xAAAA_AAAA then 0xBBBB_BBBB with m_resp[0].ready = 0 for 2 cycles: mem_resp.ready = 0 held; B not delivered before A.
REQ-028 mem_resp.valid = 1 with FIFO empty: mem_resp.ready = 0, no m_resp valid.
REQ-029 rst asserted with 2 outstanding, then a new request: FIFO empty, rr_ptr = 0, the new response routes to its new requester, not to any stale tag.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types for the two-requester memory arbiter (request/response payloads, requester ids).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: N_REQ, REQ_IF/REQ_LS, req_id_t, mreq_t, mtrans_t, arb_state_t, other_req().
package mem_arbiter_pkg;

  localparam int N_REQ = 2;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ_IF = 1'b0;  // instruction fetch
  localparam req_id_t REQ_LS = 1'b1;  // load/store

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  be;
  } mreq_t;

  typedef struct packed {
    logic [31:0] data;
  } mtrans_t;

  localparam int MREQ_W   = $bits(mreq_t);
  localparam int MTRANS_W = $bits(mtrans_t);

  // ARB_HOLD: a request was offered but not taken, so the grant is pinned.
  typedef enum logic [0:0] {
    ARB_OPEN = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// Purpose: small FIFO of tags; here it remembers which requester owns each in-flight memory request.
// Latency: push visible at head the cycle after the push; head is read combinationally.
// Backpressure: push ignored when full (no same-cycle pop bypass), pop ignored when empty.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, head, full, empty.
module tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Explicit wrap so a depth of 1 (pointer stuck at 0) behaves like the power-of-two cases.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one in-order memory port between fetch (0) and load/store (1).
// Latency: zero-cycle request path and zero-cycle response routing (both combinational).
// Backpressure: grant pinned while mem_req is stalled; all requests held off while OUTSTANDING tags are in flight.
// Ports: clk, rst; m_req_{vld,rdy,dat}[N_REQ], m_resp_{vld,rdy,dat}[N_REQ] toward requesters;
//        mem_req_{vld,rdy,dat}, mem_resp_{vld,rdy,dat} toward memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 m_req_vld,
  output logic [N_REQ-1:0]                 m_req_rdy,
  input  logic [N_REQ-1:0][MREQ_W-1:0]     m_req_dat,
  output logic [N_REQ-1:0]                 m_resp_vld,
  input  logic [N_REQ-1:0]                 m_resp_rdy,
  output logic [N_REQ-1:0][MTRANS_W-1:0]   m_resp_dat,
  output logic                             mem_req_vld,
  input  logic                             mem_req_rdy,
  output logic [MREQ_W-1:0]                mem_req_dat,
  input  logic                             mem_resp_vld,
  output logic                             mem_resp_rdy,
  input  logic [MTRANS_W-1:0]              mem_resp_dat
);

  arb_state_t state;
  arb_state_t state_nxt;
  req_id_t    rr_ptr;
  req_id_t    lock_id;
  req_id_t    gnt;
  req_id_t    fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       stalled;
  logic       resp_pop;

  // Grant selection: a stalled offer keeps its grant so the payload cannot change mid-handshake.
  always_comb begin
    gnt = REQ_IF;
    if (state == ARB_HOLD) begin
      gnt = lock_id;
    end else if (m_req_vld[REQ_IF] && m_req_vld[REQ_LS]) begin
      gnt = rr_ptr;
    end else if (m_req_vld[REQ_LS]) begin
      gnt = REQ_LS;
    end
  end

  // Request path. A full tag FIFO blocks issue outright, even if a response pops this cycle.
  always_comb begin
    mem_req_vld    = m_req_vld[gnt] && !fifo_full;
    mem_req_dat    = m_req_dat[gnt];
    m_req_rdy      = '0;
    m_req_rdy[gnt] = mem_req_rdy && !fifo_full;
  end

  assign accept  = mem_req_vld && mem_req_rdy;
  assign stalled = mem_req_vld && !mem_req_rdy;

  // Arbitration state: next-state logic.
  always_comb begin
    state_nxt = ARB_OPEN;
    if (stalled) begin
      state_nxt = ARB_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_OPEN;
      rr_ptr  <= REQ_IF;
      lock_id <= REQ_IF;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= other_req(gnt);
      end
      if (stalled) begin
        lock_id <= gnt;
      end
    end
  end

  // Response routing: memory answers in order, so the oldest tag names the owner.
  // With no tag in flight the memory side is never acknowledged.
  always_comb begin
    m_resp_vld   = '0;
    mem_resp_rdy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      m_resp_dat[i] = mem_resp_dat;
    end
    if (!fifo_empty) begin
      m_resp_vld[fifo_head] = mem_resp_vld;
      mem_resp_rdy          = m_resp_rdy[fifo_head];
    end
  end

  assign resp_pop = mem_resp_vld && mem_resp_rdy;

  tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH ($bits(req_id_t))
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (gnt),
    .pop      (resp_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (vector table, directed corner sequences, random vs reference model).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: random stimulus holds a requester's valid and payload until the model says it was accepted.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int OUT = 2;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [N_REQ-1:0]               m_req_vld;
  logic [N_REQ-1:0]               m_req_rdy;
  logic [N_REQ-1:0][MREQ_W-1:0]   m_req_dat;
  logic [N_REQ-1:0]               m_resp_vld;
  logic [N_REQ-1:0]               m_resp_rdy;
  logic [N_REQ-1:0][MTRANS_W-1:0] m_resp_dat;
  logic                           mem_req_vld;
  logic                           mem_req_rdy;
  logic [MREQ_W-1:0]              mem_req_dat;
  logic                           mem_resp_vld;
  logic                           mem_resp_rdy;
  logic [MTRANS_W-1:0]            mem_resp_dat;

  always #5 clk = ~clk;

  mem_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req_vld    (m_req_vld),
    .m_req_rdy    (m_req_rdy),
    .m_req_dat    (m_req_dat),
    .m_resp_vld   (m_resp_vld),
    .m_resp_rdy   (m_resp_rdy),
    .m_resp_dat   (m_resp_dat),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_dat  (mem_req_dat),
    .mem_resp_vld (mem_resp_vld),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_dat (mem_resp_dat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] vld, input logic mrdy, input logic rv,
                       input logic [1:0] rr, input logic [31:0] rd);
    m_req_vld    = vld;
    mem_req_rdy  = mrdy;
    mem_resp_vld = rv;
    m_resp_rdy   = rr;
    mem_resp_dat = rd;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [MREQ_W-1:0] mk_req(input int id, input int seq);
    mreq_t r;
    r.a  = {id[7:0], 8'h5A, seq[15:0]};
    r.we = seq[0];
    r.d  = {seq[15:0], id[7:0], 8'hC3};
    r.be = seq[3:0] | 4'h1;
    return r;
  endfunction

  typedef struct {
    logic [1:0] vld;
    logic       mrdy;
    logic       rvld;
    logic [1:0] rrdy;
    logic       e_mvld;
    logic [1:0] e_rdy;    // compared only on requesters that are valid
    logic       e_gnt;
    logic       e_rrdy;
    logic [1:0] e_rvld;
  } vec_t;

  vec_t tbl[16];

  // Reference model state for the random phase.
  int q[$];
  int rr_m;
  int lk_m;
  logic [1:0] cur_vld;
  int seq;

  initial begin
    logic [31:0] rdat;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic        e_rr;
    logic        e_mv;
    logic        full;
    int          g;
    int          h;

    // Rows: alternation, stall/lock, fill to OUTSTANDING, drain, stray response on empty.
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1, 2'b10};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01};
    tbl[4]  = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
    tbl[5]  = '{2'b10, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[6]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[7]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00};
    tbl[11] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
    tbl[12] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b00};
    tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01};
    tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
    tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};

    m_req_dat[0] = mk_req(0, 1);
    m_req_dat[1] = mk_req(1, 2);

    // Reset state, with a stray memory response that must not be acknowledged.
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    drive(2'b00, 1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF);
    #1;
    chk("rst_mem_req_vld", 96'(mem_req_vld), 96'(1'b0));
    chk("rst_mem_resp_rdy", 96'(mem_resp_rdy), 96'(1'b0));
    chk("rst_m_resp_vld", 96'(m_resp_vld), 96'(2'b00));
    rst = 1'b0;
    tick();

    // Table phase starts from freshly reset state.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      rdat = $urandom;
      drive(tbl[r].vld, tbl[r].mrdy, tbl[r].rvld, tbl[r].rrdy, rdat);
      #1;
      chk($sformatf("t%0d_mem_req_vld", r), 96'(mem_req_vld), 96'(tbl[r].e_mvld));
      chk($sformatf("t%0d_m_req_rdy", r), 96'(m_req_rdy & tbl[r].vld), 96'(tbl[r].e_rdy));
      if (tbl[r].e_mvld)
        chk($sformatf("t%0d_gnt_dat", r), 96'(mem_req_dat), 96'(m_req_dat[tbl[r].e_gnt]));
      chk($sformatf("t%0d_mem_resp_rdy", r), 96'(mem_resp_rdy), 96'(tbl[r].e_rrdy));
      chk($sformatf("t%0d_m_resp_vld", r), 96'(m_resp_vld), 96'(tbl[r].e_rvld));
      for (int i = 0; i < N_REQ; i++)
        if (tbl[r].e_rvld[i])
          chk($sformatf("t%0d_resp_dat%0d", r, i), 96'(m_resp_dat[i]), 96'(rdat));
      tick();
    end

    // In-order delivery: B must wait behind A while requester 0 stalls.
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
    tick();
    drive(2'b10, 1'b1, 1'b0, 2'b00, 32'h0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b10, 32'hAAAA_AAAA);
      #1;
      chk("ord_stall_mem_resp_rdy", 96'(mem_resp_rdy), 96'(1'b0));
      chk("ord_stall_m_resp_vld", 96'(m_resp_vld), 96'(2'b01));
      chk("ord_stall_dat0", 96'(m_resp_dat[0]), 96'(32'hAAAA_AAAA));
      tick();
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hAAAA_AAAA);
    #1;
    chk("ord_a_mem_resp_rdy", 96'(mem_resp_rdy), 96'(1'b1));
    chk("ord_a_m_resp_vld", 96'(m_resp_vld), 96'(2'b01));
    tick();
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hBBBB_BBBB);
    #1;
    chk("ord_b_m_resp_vld", 96'(m_resp_vld), 96'(2'b10));
    chk("ord_b_dat1", 96'(m_resp_dat[1]), 96'(32'hBBBB_BBBB));
    tick();

    // Reset with two tags in flight (owners 1 then 0, preference left on 1).
    do_reset();
    drive(2'b10, 1'b1, 1'b0, 2'b00, 32'h0);
    tick();
    drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h1234_5678);
    #1;
    chk("mid_rst_mem_resp_rdy", 96'(mem_resp_rdy), 96'(1'b0));
    chk("mid_rst_m_resp_vld", 96'(m_resp_vld), 96'(2'b00));
    drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
    #1;
    chk("mid_rst_rr_gnt", 96'(mem_req_dat), 96'(m_req_dat[0]));
    tick();
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h0BAD_F00D);
    #1;
    chk("mid_rst_route", 96'(m_resp_vld), 96'(2'b01));
    tick();

    // Random traffic against the reference model.
    do_reset();
    q.delete();
    rr_m    = 0;
    lk_m    = -1;
    cur_vld = 2'b00;
    seq     = 100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!cur_vld[i] && ($urandom_range(0, 1) == 1)) begin
          cur_vld[i]   = 1'b1;
          m_req_dat[i] = mk_req(i, seq);
          seq++;
        end
      end
      drive(cur_vld, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom);
      #1;
      full = (q.size() == OUT);
      if (lk_m >= 0)               g = lk_m;
      else if (cur_vld == 2'b11)   g = rr_m;
      else if (cur_vld[1])         g = 1;
      else                         g = 0;
      e_mv  = cur_vld[g] && !full;
      e_rdy = 2'b00;
      if (!full && mem_req_rdy) e_rdy[g] = 1'b1;
      e_rdy = e_rdy & cur_vld;
      e_rv  = 2'b00;
      e_rr  = 1'b0;
      h     = 0;
      if (q.size() > 0) begin
        h    = q[0];
        e_rr = m_resp_rdy[h];
        if (mem_resp_vld) e_rv[h] = 1'b1;
      end
      chk("rnd_mem_req_vld", 96'(mem_req_vld), 96'(e_mv));
      chk("rnd_m_req_rdy", 96'(m_req_rdy & cur_vld), 96'(e_rdy));
      if (e_mv) chk("rnd_gnt_dat", 96'(mem_req_dat), 96'(m_req_dat[g]));
      chk("rnd_mem_resp_rdy", 96'(mem_resp_rdy), 96'(e_rr));
      chk("rnd_m_resp_vld", 96'(m_resp_vld), 96'(e_rv));
      if (e_rv != 2'b00) chk("rnd_resp_dat", 96'(m_resp_dat[h]), 96'(mem_resp_dat));
      if (q.size() > 0 && mem_resp_vld && m_resp_rdy[h]) q.pop_front();
      if (e_mv && mem_req_rdy) begin
        q.push_back(g);
        rr_m       = 1 - g;
        lk_m       = -1;
        cur_vld[g] = 1'b0;
      end else if (e_mv) begin
        lk_m = g;
      end else begin
        lk_m = -1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
